// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Contents: control FSM state encoding, default operand width and the
// iteration counter width helper used by the control unit.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIN  = 2'b10
    } estado_t;

    localparam int N_DEF = 3;

    // Width needed to hold the values 0..n in the iteration counter.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/divisor_secuencial_if.sv
// Handshake/data bundle of the divider.
// master: drives inicio, D (2N-bit dividend), M (N-bit divisor);
//         observes cociente, resto, fin, error, ocupado.
// slave : the divider itself (opposite directions).
interface divisor_secuencial_if #(
    parameter int N = 3
);
    logic             inicio;
    logic [2*N-1:0]   D;
    logic [N-1:0]     M;
    logic [N-1:0]     cociente;
    logic [N-1:0]     resto;
    logic             fin;
    logic             error;
    logic             ocupado;

    modport master (
        output inicio, D, M,
        input  cociente, resto, fin, error, ocupado
    );

    modport slave (
        input  inicio, D, M,
        output cociente, resto, fin, error, ocupado
    );
endinterface

// File: rtl/divisor_secuencial_cd.sv
// cd_div: datapath of the restoring divider.
// Ports: clk, reset (sync, active-high); strobes carga_i (load operands),
// itera_i (one restoring step), escribe_i (commit result); operands d_i, m_i;
// excep_o flags divide-by-zero/overflow on the current operands (combinational,
// used only by the control unit); cociente_o, resto_o, error_o are registered.
module cd_div
    import div_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           carga_i,
    input  logic           itera_i,
    input  logic           escribe_i,
    input  logic [2*N-1:0] d_i,
    input  logic [N-1:0]   m_i,
    output logic           excep_o,
    output logic [N-1:0]   cociente_o,
    output logic [N-1:0]   resto_o,
    output logic           error_o
);
    logic [N:0]   a_q;
    logic [N-1:0] q_q;
    logic [N-1:0] mr_q;
    logic [N-1:0] cociente_q;
    logic [N-1:0] resto_q;
    logic         error_q;

    logic [N:0]   a_sh;
    logic [N-1:0] q_sh;
    logic [N+1:0] diff;
    logic         borrow;
    logic [N:0]   a_d;
    logic [N-1:0] q_d;

    // The quotient only fits in N bits when the upper half of the dividend
    // is strictly below the divisor; M==0 is caught by the same compare.
    assign excep_o = (m_i == '0) || (d_i[2*N-1:N] >= m_i);

    always_comb begin
        a_sh   = (a_q << 1) | {{N{1'b0}}, q_q[N-1]};
        q_sh   = q_q << 1;
        // One extra bit beyond the (N+1)-bit A so the MSB is a clean borrow.
        diff   = {1'b0, a_sh} - {2'b00, mr_q};
        borrow = diff[N+1];
        a_d    = borrow ? a_sh : diff[N:0];
        q_d    = {q_sh[N-1:1], ~borrow};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q        <= '0;
            q_q        <= '0;
            mr_q       <= '0;
            cociente_q <= '0;
            resto_q    <= '0;
            error_q    <= 1'b0;
        end else if (carga_i) begin
            a_q     <= {1'b0, d_i[2*N-1:N]};
            q_q     <= d_i[N-1:0];
            mr_q    <= m_i;
            error_q <= excep_o;
            if (excep_o) begin
                cociente_q <= '1;
                resto_q    <= d_i[N-1:0];
            end
        end else if (itera_i) begin
            a_q <= a_d;
            q_q <= q_d;
            if (escribe_i) begin
                cociente_q <= q_d;
                resto_q    <= a_d[N-1:0];
            end
        end
    end

    assign cociente_o = cociente_q;
    assign resto_o    = resto_q;
    assign error_o    = error_q;

endmodule

// File: rtl/divisor_secuencial.sv
// divisor_secuencial: sequential unsigned restoring divider, one quotient bit
// per clock. Holds the control FSM (state, iteration counter, fin, ocupado)
// and instantiates the cd_div datapath.
// Ports: clk, reset (sync, active-high); bus (slave): inicio, D, M in;
// cociente, resto, fin, error, ocupado out (all registered).
module divisor_secuencial
    import div_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    divisor_secuencial_if.slave  bus
);
    localparam int CNT_W = cnt_w(N);

    estado_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fin_q;
    logic             ocupado_q;

    logic carga, itera, escribe, excep;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carga   = 1'b0;
        itera   = 1'b0;
        escribe = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.inicio) begin
                    carga   = 1'b1;
                    cnt_d   = CNT_W'(N);
                    state_d = excep ? FIN : CALC;
                end
            end
            CALC: begin
                itera = 1'b1;
                cnt_d = cnt_q - 1'b1;
                // Last iteration: this edge brings the counter to zero.
                if (cnt_q == CNT_W'(1)) begin
                    escribe = 1'b1;
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fin_q     <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            // Registered from the next state so both track the FSM exactly.
            fin_q     <= (state_d == FIN);
            ocupado_q <= (state_d != IDLE);
        end
    end

    cd_div #(.N(N)) u_cd (
        .clk        (clk),
        .reset      (reset),
        .carga_i    (carga),
        .itera_i    (itera),
        .escribe_i  (escribe),
        .d_i        (bus.D),
        .m_i        (bus.M),
        .excep_o    (excep),
        .cociente_o (bus.cociente),
        .resto_o    (bus.resto),
        .error_o    (bus.error)
    );

    assign bus.fin     = fin_q;
    assign bus.ocupado = ocupado_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
module tb_divisor_secuencial;
    localparam int N = 3;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;

    divisor_secuencial_if #(.N(N)) dif ();

    divisor_secuencial #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Accept one operation and follow it to its fin pulse.
    // n_edges: edges after the accepting edge before fin is seen.
    task automatic run_op(input string tag, input int d, input int m,
                          input int exp_q, input int exp_r, input int exp_e,
                          input int exp_edges);
        int n;
        int busy;
        @(negedge clk);
        dif.inicio = 1'b1;
        dif.D      = 6'(d);
        dif.M      = 3'(m);
        @(posedge clk);
        @(negedge clk);
        dif.inicio = 1'b0;
        n    = 0;
        busy = 0;
        while (dif.fin !== 1'b1 && n < 20) begin
            if (dif.ocupado === 1'b1) busy++;
            @(negedge clk);
            n++;
        end
        if (dif.ocupado === 1'b1) busy++;
        check({tag, "_timeout"}, int'(n < 20), 1);
        check({tag, "_lat"}, n, exp_edges);
        check({tag, "_busy"}, busy, exp_edges + 1);
        check({tag, "_coc"}, int'(dif.cociente), exp_q);
        check({tag, "_resto"}, int'(dif.resto), exp_r);
        check({tag, "_err"}, int'(dif.error), exp_e);
        @(negedge clk);
        check({tag, "_fin1cyc"}, int'(dif.fin), 0);
        check({tag, "_ocup_off"}, int'(dif.ocupado), 0);
        $display("op %s D=%0d M=%0d -> coc=%0d resto=%0d err=%0d edges=%0d",
                 tag, d, m, dif.cociente, dif.resto, dif.error, n);
    endtask

    initial begin
        int n;
        int seen;
        int fin1_cyc;
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        reset      = 1'b1;
        dif.inicio = 1'b0;
        dif.D      = '0;
        dif.M      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_coc", int'(dif.cociente), 0);
        check("rst_resto", int'(dif.resto), 0);
        check("rst_fin", int'(dif.fin), 0);
        check("rst_err", int'(dif.error), 0);
        check("rst_ocup", int'(dif.ocupado), 0);
        reset = 1'b0;

        run_op("45div7", 45, 7, 6, 3, 0, 3);
        run_op("30div6", 30, 6, 5, 0, 0, 3);
        run_op("20div0", 20, 0, 7, 4, 1, 0);
        run_op("63div7", 63, 7, 7, 7, 1, 0);
        run_op("6div7", 6, 7, 0, 6, 0, 3);
        run_op("48div7", 48, 7, 6, 6, 0, 3);

        // Reset at edge t+2 of a 45/7 run.
        @(negedge clk);
        dif.inicio = 1'b1;
        dif.D      = 6'd45;
        dif.M      = 3'd7;
        @(posedge clk);
        @(negedge clk);
        dif.inicio = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_coc", int'(dif.cociente), 0);
        check("abort_resto", int'(dif.resto), 0);
        check("abort_err", int'(dif.error), 0);
        check("abort_fin", int'(dif.fin), 0);
        check("abort_ocup", int'(dif.ocupado), 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dif.fin === 1'b1) seen = 1;
        end
        check("abort_nofin", seen, 0);
        $display("op abort: reset mid-run, fin seen=%0d", seen);
        run_op("45div7_again", 45, 7, 6, 3, 0, 3);

        // Back-to-back with inicio held high.
        @(negedge clk);
        dif.inicio = 1'b1;
        dif.D      = 6'd45;
        dif.M      = 3'd7;
        n = 0;
        @(negedge clk);
        while (dif.fin !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_timeout", int'(n < 20), 1);
        fin1_cyc = cyc;
        check("b2b_first_coc", int'(dif.cociente), 6);
        check("b2b_first_resto", int'(dif.resto), 3);
        dif.D = 6'd30;
        dif.M = 3'd6;
        @(negedge clk);
        check("b2b_idle_fin", int'(dif.fin), 0);
        @(negedge clk);
        dif.inicio = 1'b0;
        check("b2b_second_busy", int'(dif.ocupado), 1);
        check("b2b_hold_coc", int'(dif.cociente), 6);
        // A stray start during CALC must be ignored.
        @(negedge clk);
        dif.inicio = 1'b1;
        dif.D      = 6'd20;
        dif.M      = 3'd0;
        @(negedge clk);
        dif.inicio = 1'b0;
        check("b2b_hold_resto", int'(dif.resto), 3);
        n = 0;
        while (dif.fin !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_second_timeout", int'(n < 20), 1);
        check("b2b_gap", cyc - fin1_cyc, 5);
        check("b2b_second_coc", int'(dif.cociente), 5);
        check("b2b_second_resto", int'(dif.resto), 0);
        check("b2b_second_err", int'(dif.error), 0);
        $display("op b2b: 45/7 then 30/6, gap=%0d coc=%0d resto=%0d",
                 cyc - fin1_cyc, dif.cociente, dif.resto);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dif.fin === 1'b1 || dif.ocupado === 1'b1) seen = 1;
        end
        check("b2b_no_third", seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
